wt_store_coalesce_buf: RTL and testbench
========================================

WT_STORE_COALESCE_BUF -- requirements
Module: wt_store_coalesce_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of write-buffer entries (2..4).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 64, memory word width; byte enables are DATA_W/8 wide.
REQ-004 SHALL have parameter TID_W, default 2, transaction-ID width; DEPTH <= 2**TID_W.
REQ-005 SHALL have ports clk_i in 1 (single clock) and rst_i in 1 (reset, synchronous, active-high).
REQ-006 SHALL have ports st_valid_i in 1, st_ready_o out 1, st_addr_i in ADDR_W, st_data_i in DATA_W, st_be_i in DATA_W/8 (store input from the cache controller).
REQ-007 SHALL have ports mem_valid_o out 1, mem_ready_i in 1, mem_addr_o out ADDR_W (word-aligned), mem_data_o out DATA_W, mem_be_o out DATA_W/8, mem_tid_o out TID_W (write request to memory).
REQ-008 SHALL have ports ack_valid_i in 1, ack_tid_i in TID_W (write completion).
REQ-009 SHALL have ports ld_addr_i in ADDR_W, ld_hit_o out 1 (load-hazard check), flush_i in 1, empty_o out 1.

Function
REQ-010 Each entry SHALL be in one of three states: FREE, PEND (waiting to issue), ISS (issued, awaiting ack).
REQ-011 A word match SHALL compare addr[ADDR_W-1:log2(DATA_W/8)] only.
REQ-012 An accepted store matching a PEND entry not being issued this cycle SHALL merge into it: be |= st_be_i; each enabled byte is overwritten with the new data.
REQ-013 An accepted store with no mergeable entry SHALL allocate the lowest-index FREE entry and set it to PEND.
REQ-014 st_ready_o SHALL be 1 iff flush_i=0 and (a mergeable PEND entry exists or a FREE entry exists at the start of the cycle); it is combinational.
REQ-015 A store SHALL never merge into an ISS entry; it allocates a new entry.
REQ-016 Issue order SHALL equal allocation order, tracked by an age FIFO of entry indices.
REQ-017 mem_valid_o SHALL be 1 when the oldest non-issued entry is PEND and no ISS entry has the same word address.
REQ-018 On mem_valid_o && mem_ready_i the entry SHALL go to ISS; mem_tid_o SHALL equal the entry index.
REQ-019 The mem_* outputs SHALL be registered-stable: while mem_valid_o=1 and mem_ready_i=0, addr/data/be/tid SHALL not change and no merge into that entry SHALL occur.
REQ-020 ack_valid_i SHALL free the ISS entry indexed by ack_tid_i next cycle; an ack to a non-ISS entry SHALL be ignored.
REQ-021 A slot freed by an ack SHALL not be allocatable in the same cycle.
REQ-022 Acks SHALL be accepted in any order.
REQ-023 ld_hit_o SHALL be combinational: 1 iff any PEND or ISS entry word-matches ld_addr_i.
REQ-024 While flush_i=1, no stores SHALL be accepted and draining SHALL continue; empty_o SHALL be 1 iff all entries are FREE.
REQ-025 Allocate, issue and ack in one cycle SHALL all take effect; the store buffer occupancy count SHALL never exceed DEPTH.

Reset
REQ-026 When rst_i=1 at a clock edge, all entries SHALL become FREE, the age FIFO SHALL empty and pointers SHALL zero.
REQ-027 After reset: mem_valid_o=0, empty_o=1, ld_hit_o=0, st_ready_o=1 (if flush_i=0).
REQ-028 Reset mid-operation SHALL discard in-flight entries; later acks for discarded tids SHALL be ignored.

Structure
REQ-029 Entry state enum (FREE/PEND/ISS) and the entry struct (addr, data, be) SHALL go in wt_store_buf_pkg, together with the word-offset width function.
REQ-030 The age FIFO SHALL be the sub-module wt_store_age_fifo (DEPTH entries of log2(DEPTH) bits, push/pop/full/empty).

Verification
REQ-031 Store 0x8000_0000 be=0x0F data=0x11223344, then 0x8000_0004 be=0xF0 while mem_ready_i=0 -> second store is held (no merge into a presented entry) and allocates entry 1; the issued word is 0x8000_0000 with be=0x0F, tid=0.
REQ-032 Two stores to 0x8000_0010 with mem_ready_i=0 before the first is presented (bytes 0 and 7) -> one request with be=0x81 and both bytes correct.
REQ-033 Fill DEPTH=2 with distinct words, then a third store -> st_ready_o=0 until ack_tid_i=0; the store is accepted the cycle after the ack.
REQ-034 Issue tid0 at 0x8000_0020, then store 0x8000_0020 again -> the new entry is not issued until tid0 is acked; ld_hit_o=1 for 0x8000_0024 throughout.
REQ-035 Acks arrive as tid1 then tid0 -> both entries are freed and empty_o=1 after the second ack.
REQ-036 Assert rst_i with one ISS entry, then ack that tid -> no state change; empty_o stays 1.

Source files
------------

// File: rtl/wt_store_buf_pkg.sv
// Shared types for the write-through store coalescing buffer:
// per-entry state, entry payload and the word-offset width helper.
package wt_store_buf_pkg;

   // Payload widths of an entry. The top-level ADDR_W/DATA_W default to these and must match them.
   localparam int unsigned SB_ADDR_W = 32;
   localparam int unsigned SB_DATA_W = 64;
   localparam int unsigned SB_BE_W   = SB_DATA_W / 8;

   typedef enum logic [1:0] {
      ST_FREE = 2'd0,
      ST_PEND = 2'd1,
      ST_ISS  = 2'd2
   } sb_state_e;

   typedef struct packed {
      logic [SB_ADDR_W-1:0] addr;
      logic [SB_DATA_W-1:0] data;
      logic [SB_BE_W-1:0]   be;
   } sb_entry_t;

   // Number of byte-offset bits inside one memory word.
   function automatic int unsigned word_off_w(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/wt_store_age_fifo.sv
// Allocation-order FIFO of entry indices; the head is the oldest entry not yet issued.
module wt_store_age_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [IDX_W-1:0] push_idx_i,
   input  logic             pop_i,
   output logic [IDX_W-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [IDX_W-1:0] slot_q [DEPTH];
   logic [IDX_W-1:0] rd_ptr_q;
   logic [IDX_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_ok;
   logic             pop_ok;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = slot_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register regardless of block order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: slot storage carries no reset; a slot is only read after the count says it was written.
   always_ff @(posedge clk_i) begin
      if (push_ok) slot_q[wr_ptr_q] <= push_idx_i;
   end

endmodule

// File: rtl/wt_store_coalesce_buf.sv
// Write-through store buffer: coalesces stores per memory word, issues them in allocation
// order, holds back a word while an older write to it is in flight, and frees slots on ack.
module wt_store_coalesce_buf
   import wt_store_buf_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = SB_ADDR_W,
   parameter int unsigned DATA_W = SB_DATA_W,
   parameter int unsigned TID_W  = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                st_valid_i,
   output logic                st_ready_o,
   input  logic [ADDR_W-1:0]   st_addr_i,
   input  logic [DATA_W-1:0]   st_data_i,
   input  logic [DATA_W/8-1:0] st_be_i,
   output logic                mem_valid_o,
   input  logic                mem_ready_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [TID_W-1:0]    mem_tid_o,
   input  logic                ack_valid_i,
   input  logic [TID_W-1:0]    ack_tid_i,
   input  logic [ADDR_W-1:0]   ld_addr_i,
   output logic                ld_hit_o,
   input  logic                flush_i,
   output logic                empty_o
);

   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned OFF_W  = word_off_w(DATA_W);
   localparam int unsigned WORD_W = ADDR_W - OFF_W;
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   sb_state_e        state_q [DEPTH];
   sb_entry_t        ent_q   [DEPTH];

   logic [IDX_W-1:0] head_idx;
   logic             fifo_full;
   logic             fifo_empty;
   logic [WORD_W-1:0] head_word;
   logic             head_block;
   logic             free_hit;
   logic [IDX_W-1:0] free_idx;
   logic             merge_hit;
   logic [IDX_W-1:0] merge_idx;
   logic             all_free;
   logic             accept;
   logic             do_alloc;
   logic             do_merge;
   logic             issue;
   logic [ADDR_W-1:0] st_word_addr;
   logic             unused_lsbs;

   function automatic logic same_word(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
      return a == b;
   endfunction

   assign st_word_addr = {st_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign head_word    = ent_q[head_idx].addr[ADDR_W-1:OFF_W];
   assign unused_lsbs  = ^{st_addr_i[OFF_W-1:0], ld_addr_i[OFF_W-1:0]};

   // A word already in flight blocks its younger copy so memory sees writes in order.
   // NOTE: every always_comb output gets a default before the loop, so no path leaves it unassigned (no latch).
   always_comb begin
      head_block = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (state_q[i] == ST_ISS && same_word(ent_q[i].addr[ADDR_W-1:OFF_W], head_word))
            head_block = 1'b1;
      end
   end

   assign mem_valid_o = !fifo_empty && (state_q[head_idx] == ST_PEND) && !head_block;
   assign issue       = mem_valid_o && mem_ready_i;
   assign mem_addr_o  = ent_q[head_idx].addr;
   assign mem_data_o  = ent_q[head_idx].data;
   assign mem_be_o    = ent_q[head_idx].be;
   assign mem_tid_o   = TID_W'(head_idx);

   // The presented entry is frozen, so a store to its word lands in a fresh entry instead.
   always_comb begin
      free_hit  = 1'b0;
      free_idx  = '0;
      merge_hit = 1'b0;
      merge_idx = '0;
      all_free  = 1'b1;
      ld_hit_o  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (state_q[i] == ST_FREE) begin
            if (!free_hit) begin
               free_hit = 1'b1;
               free_idx = IDX_W'(i);
            end
         end else begin
            all_free = 1'b0;
            if (same_word(ent_q[i].addr[ADDR_W-1:OFF_W], ld_addr_i[ADDR_W-1:OFF_W]))
               ld_hit_o = 1'b1;
         end
         if (state_q[i] == ST_PEND && !merge_hit
             && !(mem_valid_o && head_idx == IDX_W'(i))
             && same_word(ent_q[i].addr[ADDR_W-1:OFF_W], st_addr_i[ADDR_W-1:OFF_W])) begin
            merge_hit = 1'b1;
            merge_idx = IDX_W'(i);
         end
      end
   end

   assign st_ready_o = !flush_i && (merge_hit || (free_hit && !fifo_full));
   assign accept     = st_valid_i && st_ready_o;
   assign do_merge   = accept && merge_hit;
   assign do_alloc   = accept && !merge_hit;
   assign empty_o    = all_free;

   // Ack, issue and allocate always target different entries, so all three apply in one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ack_valid_i && ack_tid_i == TID_W'(i) && state_q[i] == ST_ISS)
               state_q[i] <= ST_FREE;
            if (issue && head_idx == IDX_W'(i))
               state_q[i] <= ST_ISS;
            if (do_alloc && free_idx == IDX_W'(i))
               state_q[i] <= ST_PEND;
         end
      end
   end

   // NOTE: the payload array has no reset; it is only observed through entries whose state is not FREE.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (do_alloc && free_idx == IDX_W'(i)) begin
            ent_q[i].addr <= st_word_addr;
            ent_q[i].data <= st_data_i;
            ent_q[i].be   <= st_be_i;
         end else if (do_merge && merge_idx == IDX_W'(i)) begin
            ent_q[i].be <= ent_q[i].be | st_be_i;
            for (int b = 0; b < BE_W; b++) begin
               if (st_be_i[b]) ent_q[i].data[8*b +: 8] <= st_data_i[8*b +: 8];
            end
         end
      end
   end

   wt_store_age_fifo #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_age_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (do_alloc),
      .push_idx_i (free_idx),
      .pop_i      (issue),
      .head_o     (head_idx),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

endmodule

// File: tb/tb_wt_store_coalesce_buf.sv
// Directed bench for wt_store_coalesce_buf: merge, ordering hazard, full/ack, flush and reset cases.
module tb_wt_store_coalesce_buf;

   localparam int unsigned DEPTH  = 2;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned TID_W  = 2;
   localparam int unsigned BE_W   = DATA_W / 8;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              st_valid_i;
   logic              st_ready_o;
   logic [ADDR_W-1:0] st_addr_i;
   logic [DATA_W-1:0] st_data_i;
   logic [BE_W-1:0]   st_be_i;
   logic              mem_valid_o;
   logic              mem_ready_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_data_o;
   logic [BE_W-1:0]   mem_be_o;
   logic [TID_W-1:0]  mem_tid_o;
   logic              ack_valid_i;
   logic [TID_W-1:0]  ack_tid_i;
   logic [ADDR_W-1:0] ld_addr_i;
   logic              ld_hit_o;
   logic              flush_i;
   logic              empty_o;

   int n_checks = 0;
   int n_errors = 0;

   wt_store_coalesce_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TID_W  (TID_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .st_valid_i  (st_valid_i),
      .st_ready_o  (st_ready_o),
      .st_addr_i   (st_addr_i),
      .st_data_i   (st_data_i),
      .st_be_i     (st_be_i),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
      .mem_be_o    (mem_be_o),
      .mem_tid_o   (mem_tid_o),
      .ack_valid_i (ack_valid_i),
      .ack_tid_i   (ack_tid_i),
      .ld_addr_i   (ld_addr_i),
      .ld_hit_o    (ld_hit_o),
      .flush_i     (flush_i),
      .empty_o     (empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic store(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input logic [BE_W-1:0] be);
      st_valid_i = 1'b1;
      st_addr_i  = addr;
      st_data_i  = data;
      st_be_i    = be;
      tick();
      st_valid_i = 1'b0;
   endtask

   task automatic ack(input logic [TID_W-1:0] tid);
      ack_valid_i = 1'b1;
      ack_tid_i   = tid;
      tick();
      ack_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      rst_i       = 1'b1;
      st_valid_i  = 1'b0;
      st_addr_i   = '0;
      st_data_i   = '0;
      st_be_i     = '0;
      mem_ready_i = 1'b0;
      ack_valid_i = 1'b0;
      ack_tid_i   = '0;
      ld_addr_i   = '0;
      flush_i     = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      check("rst_mem_valid", mem_valid_o, 0);
      check("rst_empty",     empty_o,     1);
      check("rst_ld_hit",    ld_hit_o,    0);
      check("rst_st_ready",  st_ready_o,  1);

      // Same word while its entry is presented: new entry, presented request unchanged.
      store(32'h8000_0000, 64'h0000_0000_1122_3344, 8'h0F);
      check("a_valid0", mem_valid_o, 1);
      store(32'h8000_0004, 64'h5566_7788_0000_0000, 8'hF0);
      check("a_valid1", mem_valid_o, 1);
      check("a_addr",   mem_addr_o,  32'h8000_0000);
      check("a_be",     mem_be_o,    8'h0F);
      check("a_data",   mem_data_o & 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1122_3344);
      check("a_tid",    mem_tid_o,   0);
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      check("a_hazard_hold", mem_valid_o, 0);
      ack(0);
      check("a_second_valid", mem_valid_o, 1);
      check("a_second_tid",   mem_tid_o,   1);
      check("a_second_addr",  mem_addr_o,  32'h8000_0000);
      check("a_second_be",    mem_be_o,    8'hF0);
      check("a_second_data",  mem_data_o & 64'hFFFF_FFFF_0000_0000, 64'h5566_7788_0000_0000);
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      ack(1);
      check("a_empty", empty_o, 1);

      // Coalesce bytes 0 and 7 of one word while an older entry stalls the port.
      store(32'h8000_0000, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
      store(32'h8000_0010, 64'h0000_0000_0000_00EE, 8'h01);
      st_valid_i = 1'b1;
      st_addr_i  = 32'h8000_0017;
      st_data_i  = 64'hDD00_0000_0000_0000;
      st_be_i    = 8'h80;
      #1;
      check("b_merge_ready", st_ready_o, 1);
      tick();
      st_valid_i = 1'b0;
      check("b_stall_tid",  mem_tid_o,  0);
      check("b_stall_addr", mem_addr_o, 32'h8000_0000);
      mem_ready_i = 1'b1;
      tick();
      check("b_valid", mem_valid_o, 1);
      check("b_addr",  mem_addr_o,  32'h8000_0010);
      check("b_be",    mem_be_o,    8'h81);
      check("b_data",  mem_data_o & 64'hFF00_0000_0000_00FF, 64'hDD00_0000_0000_00EE);
      check("b_tid",   mem_tid_o,   1);
      tick();
      mem_ready_i = 1'b0;
      check("b_drained", mem_valid_o, 0);

      // Out-of-order acks.
      ack(1);
      check("b_empty_after_tid1", empty_o, 0);
      ld_addr_i = 32'h8000_0010;
      #1;
      check("b_ld_freed", ld_hit_o, 0);
      ld_addr_i = 32'h8000_0000;
      #1;
      check("b_ld_held", ld_hit_o, 1);
      ack(0);
      check("b_empty_after_tid0", empty_o, 1);

      // Full buffer: third store waits for an ack and is taken the cycle after it.
      store(32'h8000_0100, 64'h0000_0000_0000_0100, 8'hFF);
      store(32'h8000_0200, 64'h0000_0000_0000_0200, 8'hFF);
      st_valid_i = 1'b1;
      st_addr_i  = 32'h8000_0300;
      st_data_i  = 64'h0000_0000_0000_0300;
      st_be_i    = 8'hFF;
      #1;
      check("c_full_ready", st_ready_o, 0);
      mem_ready_i = 1'b1;
      tick();
      check("c_iss0_ready", st_ready_o, 0);
      tick();
      mem_ready_i = 1'b0;
      check("c_iss1_ready", st_ready_o, 0);
      check("c_iss1_valid", mem_valid_o, 0);
      ack_valid_i = 1'b1;
      ack_tid_i   = 0;
      #1;
      check("c_ack_cycle_ready", st_ready_o, 0);
      tick();
      ack_valid_i = 1'b0;
      check("c_after_ack_ready", st_ready_o, 1);
      tick();
      st_valid_i = 1'b0;
      check("c_new_valid", mem_valid_o, 1);
      check("c_new_tid",   mem_tid_o,   0);
      check("c_new_addr",  mem_addr_o,  32'h8000_0300);
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      ack(1);
      ack(0);
      check("c_empty", empty_o, 1);

      // Store to a word in flight waits for the ack; load hazard stays visible.
      store(32'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF);
      mem_ready_i = 1'b1;
      tick();
      store(32'h8000_0020, 64'h0000_0000_0000_00AA, 8'h0F);
      ld_addr_i = 32'h8000_0024;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("d_blocked_valid", mem_valid_o, 0);
         check("d_blocked_ld_hit", ld_hit_o, 1);
         tick();
      end
      ack(0);
      check("d_valid_after_ack", mem_valid_o, 1);
      check("d_tid_after_ack",   mem_tid_o,   1);
      check("d_be_after_ack",    mem_be_o,    8'h0F);
      check("d_ld_hit_pend",     ld_hit_o,    1);
      tick();
      mem_ready_i = 1'b0;
      check("d_ld_hit_iss", ld_hit_o, 1);
      ack(1);
      check("d_ld_hit_done", ld_hit_o, 0);
      check("d_empty",       empty_o,  1);

      // Flush: no new stores, draining continues.
      store(32'h8000_0040, 64'h0000_0000_0000_0040, 8'hFF);
      flush_i    = 1'b1;
      st_valid_i = 1'b1;
      st_addr_i  = 32'h8000_0080;
      st_data_i  = 64'h0000_0000_0000_0080;
      st_be_i    = 8'hFF;
      #1;
      check("e_flush_ready", st_ready_o, 0);
      tick();
      check("e_flush_valid", mem_valid_o, 1);
      check("e_flush_addr",  mem_addr_o,  32'h8000_0040);
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      check("e_no_alloc", mem_valid_o, 0);
      check("e_not_empty", empty_o, 0);
      ack(0);
      check("e_empty", empty_o, 1);
      flush_i    = 1'b0;
      st_valid_i = 1'b0;
      #1;
      check("e_ready_after_flush", st_ready_o, 1);

      // Reset with an issued entry; the late ack must be ignored.
      store(32'h8000_0050, 64'h0000_0000_0000_0050, 8'hFF);
      mem_ready_i = 1'b1;
      tick();
      mem_ready_i = 1'b0;
      ld_addr_i = 32'h8000_0050;
      #1;
      check("f_ld_hit_iss", ld_hit_o, 1);
      check("f_not_empty",  empty_o,  0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("f_rst_empty", empty_o,     1);
      check("f_rst_valid", mem_valid_o, 0);
      check("f_rst_ld",    ld_hit_o,    0);
      ack(0);
      check("f_ack_empty", empty_o,     1);
      check("f_ack_valid", mem_valid_o, 0);
      check("f_ack_ready", st_ready_o,  1);
      store(32'h8000_0060, 64'h0000_0000_0000_0060, 8'hFF);
      check("f_new_valid", mem_valid_o, 1);
      check("f_new_tid",   mem_tid_o,   0);
      check("f_new_addr",  mem_addr_o,  32'h8000_0060);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
